// File: rtl/preg_freelist.sv
// Physical-register free list: dual-slot rename allocation, dual-slot commit release, flush rollback.
// Optional FREELIST_DBG_EN adds a sticky dbg_double_free output backed by an in-list bitmap.
module preg_freelist #(
  parameter  int unsigned PREG_NUM = 64,
  parameter  int unsigned FL_SIZE  = 32,
  parameter  int unsigned FL_LOG   = 5,
  localparam int unsigned PREG_W   = $clog2(PREG_NUM)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc0_req,
  input  logic              alloc1_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc0_prd,
  output logic [PREG_W-1:0] alloc1_prd,
  input  logic              commits0_valid,
  input  logic              commits0_need_to_wb,
  input  logic [PREG_W-1:0] commits0_old_prd,
  input  logic              commits1_valid,
  input  logic              commits1_need_to_wb,
  input  logic [PREG_W-1:0] commits1_old_prd,
  input  logic              flush_valid,
  output logic [FL_LOG:0]   free_count
`ifdef FREELIST_DBG_EN
  ,
  output logic              dbg_double_free
`endif
);

  typedef logic [FL_LOG:0] ptr_t;

  logic [PREG_W-1:0] list [FL_SIZE];
  ptr_t              head, arch_head, tail;
  ptr_t              alloc1_ptr, tail1_ptr, flush_head;
  logic              f0, f1, c0, c1;
  logic [1:0]        n_alloc, n_free, n_commit;

  assign free_count  = tail - head;
  assign alloc_ready = (free_count >= ptr_t'(2)) & ~flush_valid;

  assign alloc1_ptr  = head + ptr_t'(alloc0_req);
  assign alloc0_prd  = list[head[FL_LOG-1:0]];
  assign alloc1_prd  = list[alloc1_ptr[FL_LOG-1:0]];

  // Register 0 is never a real destination, so releasing it is suppressed.
  assign f0 = commits0_valid & commits0_need_to_wb & (commits0_old_prd != '0);
  assign f1 = commits1_valid & commits1_need_to_wb & (commits1_old_prd != '0);
  assign c0 = commits0_valid & commits0_need_to_wb;
  assign c1 = commits1_valid & commits1_need_to_wb;

  assign n_alloc    = alloc_ready ? ({1'b0, alloc0_req} + {1'b0, alloc1_req}) : 2'd0;
  assign n_free     = {1'b0, f0} + {1'b0, f1};
  assign n_commit   = {1'b0, c0} + {1'b0, c1};
  assign tail1_ptr  = tail + ptr_t'(f0);
  assign flush_head = arch_head + ptr_t'(n_commit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FL_SIZE; i++)
        list[i] <= PREG_W'(PREG_NUM - FL_SIZE + i);
      head      <= '0;
      arch_head <= '0;
      tail      <= {1'b1, {FL_LOG{1'b0}}};
    end else begin
      if (f0) list[tail[FL_LOG-1:0]]      <= commits0_old_prd;
      if (f1) list[tail1_ptr[FL_LOG-1:0]] <= commits1_old_prd;
      tail      <= tail + ptr_t'(n_free);
      arch_head <= flush_head;
      head      <= flush_valid ? flush_head : head + ptr_t'(n_alloc);
    end
  end

`ifdef FREELIST_DBG_EN
  logic [PREG_NUM-1:0] in_list, in_next;
  logic                dbl;
  logic [FL_LOG-1:0]   dist;
  ptr_t                rb_cnt;

  assign rb_cnt = head - flush_head;

  // A flush hands the rolled-back window [flush_head, head) back to the list.
  always_comb begin
    in_next = in_list;
    dbl     = 1'b0;
    dist    = '0;
    if (flush_valid) begin
      for (int unsigned i = 0; i < FL_SIZE; i++) begin
        dist = FL_LOG'(i) - flush_head[FL_LOG-1:0];
        if ({1'b0, dist} < rb_cnt) in_next[list[i]] = 1'b1;
      end
    end
    if (alloc_ready & alloc0_req) begin
      if (!in_list[alloc0_prd]) dbl = 1'b1;
      in_next[alloc0_prd] = 1'b0;
    end
    if (alloc_ready & alloc1_req) begin
      if (!in_list[alloc1_prd]) dbl = 1'b1;
      in_next[alloc1_prd] = 1'b0;
    end
    if (f0) begin
      if (in_next[commits0_old_prd]) dbl = 1'b1;
      in_next[commits0_old_prd] = 1'b1;
    end
    if (f1) begin
      if (in_next[commits1_old_prd]) dbl = 1'b1;
      in_next[commits1_old_prd] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PREG_NUM; i++)
        in_list[i] <= (i >= PREG_NUM - FL_SIZE);
      dbg_double_free <= 1'b0;
    end else begin
      in_list <= in_next;
      if (dbl) dbg_double_free <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (free_count <= ptr_t'(FL_SIZE));
      assert (ptr_t'(head - arch_head) <= ptr_t'(FL_SIZE));
    end
  end
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Directed vector table plus hand-written reset/flush sequences and a queue-model random run for preg_freelist.
module tb_preg_freelist;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       alloc0_req, alloc1_req, alloc_ready;
  logic [5:0] alloc0_prd, alloc1_prd;
  logic       commits0_valid, commits0_need_to_wb;
  logic [5:0] commits0_old_prd;
  logic       commits1_valid, commits1_need_to_wb;
  logic [5:0] commits1_old_prd;
  logic       flush_valid;
  logic [5:0] free_count;
`ifdef FREELIST_DBG_EN
  logic       dbg_double_free;
`endif

  int checks = 0;
  int errors = 0;

  preg_freelist #(.PREG_NUM(64), .FL_SIZE(32), .FL_LOG(5)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .alloc0_req          (alloc0_req),
    .alloc1_req          (alloc1_req),
    .alloc_ready         (alloc_ready),
    .alloc0_prd          (alloc0_prd),
    .alloc1_prd          (alloc1_prd),
    .commits0_valid      (commits0_valid),
    .commits0_need_to_wb (commits0_need_to_wb),
    .commits0_old_prd    (commits0_old_prd),
    .commits1_valid      (commits1_valid),
    .commits1_need_to_wb (commits1_need_to_wb),
    .commits1_old_prd    (commits1_old_prd),
    .flush_valid         (flush_valid),
    .free_count          (free_count)
`ifdef FREELIST_DBG_EN
    ,
    .dbg_double_free     (dbg_double_free)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       a0, a1;
    logic       c0v, c0w;
    logic [5:0] c0p;
    logic       c1v, c1w;
    logic [5:0] c1p;
    logic       fl;
    int         e_rdy, e_p0, e_p1, e_fc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic a0, input logic a1,
                              input logic c0v, input logic c0w, input int c0p,
                              input logic c1v, input logic c1w, input int c1p,
                              input logic fl,
                              input int rdy, input int p0, input int p1, input int fc);
    vec_t v;
    v.a0 = a0; v.a1 = a1;
    v.c0v = c0v; v.c0w = c0w; v.c0p = 6'(c0p);
    v.c1v = c1v; v.c1w = c1w; v.c1p = 6'(c1p);
    v.fl = fl;
    v.e_rdy = rdy; v.e_p0 = p0; v.e_p1 = p1; v.e_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alloc0_req          = v.a0;
    alloc1_req          = v.a1;
    commits0_valid      = v.c0v;
    commits0_need_to_wb = v.c0w;
    commits0_old_prd    = v.c0p;
    commits1_valid      = v.c1v;
    commits1_need_to_wb = v.c1w;
    commits1_old_prd    = v.c1p;
    flush_valid         = v.fl;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Asserts reset away from a clock edge, checks the reset state while it is held, releases on negedge.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, "_fc"},  int'(free_count), 32);
    chk({tag, "_rdy"}, int'(alloc_ready), 1);
    chk({tag, "_p0"},  int'(alloc0_prd), 32);
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    int fq[$];
    int iq[$];
    int arch[32];

    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_fc",  int'(free_count), 32);
    chk("reset_rdy", int'(alloc_ready), 1);
    chk("reset_p0",  int'(alloc0_prd), 32);
    chk("reset_p1",  int'(alloc1_prd), 32);
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();

    // 16 dual allocations drain the list: head advances by 2 per cycle.
    for (int k = 0; k < 16; k++)
      tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32 + 2*k, 33 + 2*k, 32 - 2*k));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32, 33, 0));   // empty, dual req dropped
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 33, 0));   // empty, single req dropped
    tv.push_back(mk(0, 0, 1, 1, 5, 1, 1, 7, 0, 0, 32, 32, 0));   // free 5 and 7
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 7, 2));     // reallocate 5,7
    tv.push_back(mk(0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 34, 34, 0));   // free 9
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 35, 1));    // fc=1: dropped
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 1));     // head stable
    tv.push_back(mk(0, 0, 1, 1, 0, 1, 0, 11, 0, 0, 9, 9, 1));    // old_prd 0 and non-writer: no free
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 1));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 9, 35, 1));    // flush to arch_head=4, alloc ignored
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 36, 36, 31));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 36, 36, 31));  // slot1-only alloc
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 37, 37, 30));

    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      chk($sformatf("vec%0d_rdy", i), int'(alloc_ready), tv[i].e_rdy);
      chk($sformatf("vec%0d_p0",  i), int'(alloc0_prd),  tv[i].e_p0);
      chk($sformatf("vec%0d_p1",  i), int'(alloc1_prd),  tv[i].e_p1);
      chk($sformatf("vec%0d_fc",  i), int'(free_count),  tv[i].e_fc);
      next_cycle();
    end

    // Reset mid-operation, then alloc 4, flush with one commit in the same cycle.
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset("async_rst");
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("fl_a_p0", int'(alloc0_prd), 32);
    chk("fl_a_p1", int'(alloc1_prd), 33);
    next_cycle();
    #1;
    chk("fl_b_p0", int'(alloc0_prd), 34);
    chk("fl_b_p1", int'(alloc1_prd), 35);
    next_cycle();
    drive(mk(1, 1, 1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("fl_c_rdy", int'(alloc_ready), 0);
    chk("fl_c_fc",  int'(free_count), 28);
    next_cycle();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("fl_d_rdy", int'(alloc_ready), 1);
    chk("fl_d_p0",  int'(alloc0_prd), 33);
    chk("fl_d_fc",  int'(free_count), 32);
    next_cycle();

    // Random alloc/commit against a queue model of the free list and in-flight allocations.
    idle();
    do_reset("rand_rst");
    for (int i = 0; i < 32; i++) begin
      fq.push_back(32 + i);
      arch[i] = i;
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      int  k, sel, p, j, old0, old1;
      logic r0, r1, w0, w1, v0;
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      k  = $urandom_range(0, 2);
      if (k > iq.size()) k = iq.size();
      sel = $urandom_range(0, 1);
      v0 = 1'b0; w0 = 1'b0; w1 = 1'b0; old0 = 0; old1 = 0;
      if (k == 2 || (k == 1 && sel == 0)) begin
        v0 = 1'b1; w0 = 1'b1;
        p = iq.pop_front(); j = $urandom_range(1, 31);
        old0 = arch[j]; arch[j] = p;
      end else if (sel == 1) begin
        v0 = 1'b1;   // non-writer in slot0
        old0 = $urandom_range(1, 63);
      end
      if (k == 2 || (k == 1 && sel == 1)) begin
        w1 = 1'b1;
        p = iq.pop_front(); j = $urandom_range(1, 31);
        old1 = arch[j]; arch[j] = p;
      end
      drive(mk(r0, r1, v0, w0, old0, w1, w1, old1, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("rand%0d_fc", cyc), int'(free_count), fq.size());
      chk($sformatf("rand%0d_rdy", cyc), int'(alloc_ready), int'(fq.size() >= 2));
      if (fq.size() >= 2) begin
        int exp1;
        if (r0) begin
          chk($sformatf("rand%0d_p0", cyc), int'(alloc0_prd), fq[0]);
          chk($sformatf("rand%0d_dup0", cyc), int'(int'(alloc0_prd) inside {iq}), 0);
        end
        if (r1) begin
          exp1 = r0 ? fq[1] : fq[0];
          chk($sformatf("rand%0d_p1", cyc), int'(alloc1_prd), exp1);
          chk($sformatf("rand%0d_dup1", cyc), int'(int'(alloc1_prd) inside {iq}), 0);
        end
        if (r0) iq.push_back(fq.pop_front());
        if (r1) iq.push_back(fq.pop_front());
      end
      if (w0) fq.push_back(old0);
      if (w1) fq.push_back(old1);
      next_cycle();
    end
    idle();
    #1;
    chk("rand_end_fc", int'(free_count), fq.size());
    chk("rand_end_cons", int'(free_count) + iq.size() + 32, 64);

`ifdef FREELIST_DBG_EN
    chk("dbg_clean", int'(dbg_double_free), 0);
    do_reset("dbg_rst");
    drive(mk(0, 0, 1, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    idle();
    #1;
    chk("dbg_set", int'(dbg_double_free), 1);
    next_cycle();
    chk("dbg_hold", int'(dbg_double_free), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
